// File: rtl/fetch_unit_pkg.sv
// Shared word size, fetch FSM encodings and the buffered-instruction record
// used by the fetch stage and its skid buffer.
package fetch_unit_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    FETCH_ST   = 2'd0,
    SKID_ST    = 2'd1,
    DISCARD_ST = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_SIZE-1:0] instr;
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] pred_pc;
    logic                 pred_hit;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an instruction that completed while ID was stalled.
module fetch_skid_buffer
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         unload,
  input  logic         clear,
  input  fetch_entry_t entry_in,
  output fetch_entry_t entry,
  output logic         valid
);

  // Clear beats load so a redirect never leaves a stale entry behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      entry <= entry_in;
      valid <= 1'b1;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs the memory handshake and
// fills the IF/ID register, absorbing ID stalls and redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [WORD_SIZE-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [WORD_SIZE-1:0] pc,
  input  logic [WORD_SIZE-1:0] pred_pc,
  input  logic                 pred_tag_match,
  output logic                 i_mem_req,
  output logic [WORD_SIZE-1:0] i_mem_addr,
  input  logic                 i_mem_ready,
  input  logic [WORD_SIZE-1:0] i_mem_data,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 if_id_valid,
  output logic [WORD_SIZE-1:0] if_id_instr,
  output logic [WORD_SIZE-1:0] if_id_pc,
  output logic [WORD_SIZE-1:0] if_id_pred_pc,
  output logic                 if_id_pred_hit
);

  fetch_state_t         state;
  fetch_entry_t         fetched;
  fetch_entry_t         if_id_q;
  fetch_entry_t         skid_entry;
  logic                 skid_valid;
  logic                 skid_load;
  logic                 skid_unload;
  logic                 completion;
  logic [WORD_SIZE-1:0] discard_target;

  assign i_mem_addr     = pc;
  assign completion     = i_mem_req && i_mem_ready;
  assign if_id_instr    = if_id_q.instr;
  assign if_id_pc       = if_id_q.pc;
  assign if_id_pred_pc  = if_id_q.pred_pc;
  assign if_id_pred_hit = if_id_q.pred_hit;

  always_comb begin
    fetched          = '0;
    fetched.instr    = i_mem_data;
    fetched.pc       = pc;
    fetched.pred_pc  = pred_pc;
    fetched.pred_hit = pred_tag_match;
  end

  assign skid_load   = !redirect && (state == FETCH_ST) && completion && stall;
  assign skid_unload = !redirect && (state == SKID_ST) && !stall;

  fetch_skid_buffer u_skid (
    .clk      (clk),
    .reset    (reset),
    .load     (skid_load),
    .unload   (skid_unload),
    .clear    (redirect),
    .entry_in (fetched),
    .entry    (skid_entry),
    .valid    (skid_valid)
  );

  // A redirect against an unfinished request keeps pc (and so i_mem_addr)
  // frozen until the memory answers; the new target waits in discard_target.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= RESET_PC;
      i_mem_req      <= 1'b0;
      state          <= FETCH_ST;
      discard_target <= '0;
      if_id_valid    <= 1'b0;
      if_id_q        <= '0;
    end else if (redirect) begin
      if_id_valid <= 1'b0;
      if (i_mem_req && !i_mem_ready) begin
        discard_target <= redirect_pc;
        state          <= DISCARD_ST;
      end else begin
        pc        <= redirect_pc;
        i_mem_req <= 1'b1;
        state     <= FETCH_ST;
      end
    end else begin
      case (state)
        FETCH_ST: begin
          i_mem_req <= 1'b1;
          if (completion) begin
            pc <= pred_pc;
            if (stall) begin
              i_mem_req <= 1'b0;
              state     <= SKID_ST;
            end else begin
              if_id_q     <= fetched;
              if_id_valid <= 1'b1;
            end
          end else if (!stall) begin
            if_id_valid <= 1'b0;
          end
        end
        SKID_ST: begin
          if (!stall) begin
            if_id_q     <= skid_entry;
            if_id_valid <= skid_valid;
            i_mem_req   <= 1'b1;
            state       <= FETCH_ST;
          end
        end
        DISCARD_ST: begin
          if (i_mem_ready) begin
            pc    <= discard_target;
            state <= FETCH_ST;
          end
        end
        default: state <= FETCH_ST;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: model memory returns pc^16'hA500, predictor is pc+1
// with an optional one-address override; expected values are hand-computed.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [WORD_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] pred_pc;
  logic                 pred_tag_match;
  logic                 i_mem_req;
  logic [WORD_SIZE-1:0] i_mem_addr;
  logic                 i_mem_ready;
  logic [WORD_SIZE-1:0] i_mem_data;
  logic                 stall;
  logic                 redirect;
  logic [WORD_SIZE-1:0] redirect_pc;
  logic                 if_id_valid;
  logic [WORD_SIZE-1:0] if_id_instr;
  logic [WORD_SIZE-1:0] if_id_pc;
  logic [WORD_SIZE-1:0] if_id_pred_pc;
  logic                 if_id_pred_hit;

  logic                 mem_auto;
  logic                 mem_ready_manual;
  logic                 ovr_en;
  logic [WORD_SIZE-1:0] ovr_pc;
  logic [WORD_SIZE-1:0] ovr_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign i_mem_ready    = mem_auto ? i_mem_req : mem_ready_manual;
  assign i_mem_data     = i_mem_addr ^ 16'hA500;
  assign pred_pc        = (ovr_en && pc == ovr_pc) ? ovr_val : pc + 16'd1;
  assign pred_tag_match = pc[0];

  fetch_unit #(.RESET_PC(16'h0010)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .pred_pc        (pred_pc),
    .pred_tag_match (pred_tag_match),
    .i_mem_req      (i_mem_req),
    .i_mem_addr     (i_mem_addr),
    .i_mem_ready    (i_mem_ready),
    .i_mem_data     (i_mem_data),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pred_pc  (if_id_pred_pc),
    .if_id_pred_hit (if_id_pred_hit)
  );

  task automatic checkOutput(input string tag, input logic [WORD_SIZE-1:0] actual,
                             input logic [WORD_SIZE-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's inputs, then let a rising edge pass and settle.
  task automatic applyStimulus(input logic rst, input logic stl, input logic redir,
                               input logic [WORD_SIZE-1:0] rpc);
    reset       = rst;
    stall       = stl;
    redirect    = redir;
    redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    mem_auto = 1'b1; mem_ready_manual = 1'b0;
    ovr_en = 1'b0; ovr_pc = '0; ovr_val = '0;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    applyStimulus(1, 0, 0, 16'h0);
    applyStimulus(1, 0, 0, 16'h0);
    checkOutput("rst_pc", pc, 16'h0010);
    checkOutput("rst_req", {15'd0, i_mem_req}, 16'h0);
    checkOutput("rst_valid", {15'd0, if_id_valid}, 16'h0);
    checkOutput("rst_instr", if_id_instr, 16'h0);
    checkOutput("rst_ifid_pc", if_id_pc, 16'h0);
    checkOutput("rst_pred_pc", if_id_pred_pc, 16'h0);
    checkOutput("rst_pred_hit", {15'd0, if_id_pred_hit}, 16'h0);

    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("first_req", {15'd0, i_mem_req}, 16'h1);
    checkOutput("first_pc", pc, 16'h0010);
    checkOutput("first_valid", {15'd0, if_id_valid}, 16'h0);

    ovr_en = 1'b1; ovr_pc = 16'h0012; ovr_val = 16'h0040;
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("seq_pc11", pc, 16'h0011);
    checkOutput("seq_valid", {15'd0, if_id_valid}, 16'h1);
    checkOutput("seq_instr10", if_id_instr, 16'hA510);
    checkOutput("seq_ifid_pc10", if_id_pc, 16'h0010);
    checkOutput("seq_pred10", if_id_pred_pc, 16'h0011);
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("seq_pc12", pc, 16'h0012);
    checkOutput("seq_ifid_pc11", if_id_pc, 16'h0011);
    checkOutput("seq_hit11", {15'd0, if_id_pred_hit}, 16'h1);
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("taken_pc", pc, 16'h0040);
    checkOutput("taken_ifid_pc", if_id_pc, 16'h0012);
    checkOutput("taken_pred_pc", if_id_pred_pc, 16'h0040);
    ovr_en = 1'b0;

    // Completion of 0x40 under stall, held for three cycles.
    applyStimulus(0, 1, 0, 16'h0);
    checkOutput("skid_req0", {15'd0, i_mem_req}, 16'h0);
    checkOutput("skid_pc", pc, 16'h0041);
    checkOutput("skid_hold_pc0", if_id_pc, 16'h0012);
    for (int i = 1; i < 3; i++) begin
      applyStimulus(0, 1, 0, 16'h0);
      checkOutput("skid_req", {15'd0, i_mem_req}, 16'h0);
      checkOutput("skid_hold_pc", if_id_pc, 16'h0012);
      checkOutput("skid_hold_valid", {15'd0, if_id_valid}, 16'h1);
    end
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("unskid_ifid_pc", if_id_pc, 16'h0040);
    checkOutput("unskid_instr", if_id_instr, 16'hA540);
    checkOutput("unskid_req", {15'd0, i_mem_req}, 16'h1);
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("after_skid_ifid_pc", if_id_pc, 16'h0041);
    checkOutput("after_skid_pc", pc, 16'h0042);

    // Slow memory: redirect lands in the second wait cycle of the 0x42 request.
    mem_auto = 1'b0; mem_ready_manual = 1'b0;
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("wait_valid", {15'd0, if_id_valid}, 16'h0);
    applyStimulus(0, 0, 1, 16'h0080);
    checkOutput("discard_addr", i_mem_addr, 16'h0042);
    checkOutput("discard_req", {15'd0, i_mem_req}, 16'h1);
    mem_ready_manual = 1'b1;
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("drain_valid", {15'd0, if_id_valid}, 16'h0);
    checkOutput("drain_pc", pc, 16'h0080);
    checkOutput("drain_req", {15'd0, i_mem_req}, 16'h1);
    mem_auto = 1'b1;
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("refetch_ifid_pc", if_id_pc, 16'h0080);
    checkOutput("refetch_valid", {15'd0, if_id_valid}, 16'h1);

    // Redirect together with ready and stall.
    applyStimulus(0, 1, 1, 16'h0020);
    checkOutput("rsr_pc", pc, 16'h0020);
    checkOutput("rsr_valid", {15'd0, if_id_valid}, 16'h0);
    checkOutput("rsr_req", {15'd0, i_mem_req}, 16'h1);
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("rsr_next_ifid_pc", if_id_pc, 16'h0020);
    checkOutput("rsr_next_pc", pc, 16'h0021);

    // PC wrap through the predictor.
    applyStimulus(0, 0, 1, 16'hFFFF);
    checkOutput("wrap_pc", pc, 16'hFFFF);
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("wrap_next_pc", pc, 16'h0000);
    checkOutput("wrap_ifid_pc", if_id_pc, 16'hFFFF);
    checkOutput("wrap_pred_pc", if_id_pred_pc, 16'h0000);

    // Reset while a request waits for memory.
    mem_auto = 1'b0; mem_ready_manual = 1'b0;
    applyStimulus(0, 0, 0, 16'h0);
    applyStimulus(1, 0, 0, 16'h0);
    checkOutput("midrst_pc", pc, 16'h0010);
    checkOutput("midrst_req", {15'd0, i_mem_req}, 16'h0);
    checkOutput("midrst_valid", {15'd0, if_id_valid}, 16'h0);
    checkOutput("midrst_instr", if_id_instr, 16'h0);
    checkOutput("midrst_ifid_pc", if_id_pc, 16'h0);
    checkOutput("midrst_pred_pc", if_id_pred_pc, 16'h0);
    mem_auto = 1'b1;
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("postrst_req", {15'd0, i_mem_req}, 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly upstream of the branch predictor and feeding the IF/ID boundary. Holds the architectural fetch PC, drives it to the predictor and the instruction memory, and advances it to the predictor's `branch_predicted_pc` on each completed fetch. Handles variable-latency memory handshakes, ID-stage stalls through a one-entry skid buffer, and redirects (mispredict or jump resolution) that may arrive while a fetch is in flight.

## Interface
- `WORD_SIZE`, 16: PC and instruction width.
- `RESET_PC`, 16'h0000: PC loaded on reset.

- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `pc`  out  WORD_SIZE: current fetch address; goes to the predictor `pc` input and to `i_mem_addr`.
- `pred_pc`  in  WORD_SIZE: predictor's next-PC for `pc`; combinational from `pc`.
- `pred_tag_match`  in  1: predictor tag hit for `pc`.
- `i_mem_req`  out  1: fetch request.
- `i_mem_addr`  out  WORD_SIZE: equals `pc`.
- `i_mem_ready`  in  1: data valid this cycle; completes the request.
- `i_mem_data`  in  WORD_SIZE: instruction word.
- `stall`  in  1: ID cannot accept; IF/ID outputs hold.
- `redirect`  in  1: flush and refetch from `redirect_pc`.
- `redirect_pc`  in  WORD_SIZE: corrected PC.
- `if_id_valid`  out  1: IF/ID register holds a live instruction.
- `if_id_instr`  out  WORD_SIZE: fetched instruction.
- `if_id_pc`  out  WORD_SIZE: its PC.
- `if_id_pred_pc`  out  WORD_SIZE: predicted next PC, kept for resolution in ID/EX.
- `if_id_pred_hit`  out  1: `pred_tag_match` captured with the instruction.

## Operation
- States: FETCH (request issued or pending), SKID (one completed instruction buffered, waiting on stall), DISCARD (redirect arrived mid-request; drain it).
- Memory rule: `i_mem_req`/`i_mem_addr` stay stable from assertion until the cycle `i_mem_ready`=1. A request cannot be cancelled.
- FETCH, ready=1, no stall, no redirect: capture {data, pc, pred_pc, pred_tag_match} into IF/ID with valid=1, and set `pc`<=`pred_pc`. `i_mem_req` stays high for the next address.
- FETCH, ready=1, stall=1: capture into the skid entry and go to SKID. `pc`<=`pred_pc`. `i_mem_req`=0 while in SKID.
- SKID, stall=0: the skid entry moves to IF/ID and the state returns to FETCH. The request is re-asserted in the same cycle.
- stall=1 with no completion: IF/ID holds. A pending request continues to wait for ready.
- Redirect has priority over stall and completion:
  - `pc`<=`redirect_pc`.
  - `if_id_valid`<=0 and the skid entry is cleared.
  - Data completing in the same cycle is dropped.
  - If a request is pending and ready=0, go to DISCARD. In DISCARD, drop the data when ready arrives, then go to FETCH at the stored PC.
- A redirect during DISCARD overwrites the stored PC. Last redirect wins.
- PC arithmetic is handled entirely by the predictor. It is modulo 2^WORD_SIZE, so 16'hFFFF wraps to 16'h0000.

## Timing
- Reset values:
  - `pc`=RESET_PC, `i_mem_req`=0, state FETCH.
  - `if_id_valid`=0, `if_id_instr`=0, `if_id_pc`=0, `if_id_pred_pc`=0, `if_id_pred_hit`=0.
  - Skid entry empty.
- `i_mem_req`=1 in the first cycle after reset deasserts.
- Reset asserted mid-request abandons it. The memory side must tolerate the request being dropped.
- Latency: completion in cycle N makes IF/ID valid in N+1. With zero-wait memory, throughput is 1 instruction/cycle.
- Redirect in cycle N, no pending request: request at `redirect_pc` in N+1, `if_id_valid`=0 in N+1.
- `stall` is sampled every cycle. IF/ID changes only on a cycle where stall=0 or redirect=1.

## Structure
- `WORD_SIZE` comes from `constants.v`. Add the state encodings `FETCH_ST`, `SKID_ST`, `DISCARD_ST` there.
- One sub-module: `fetch_skid_buffer`, a 1-entry register with load, unload and clear.

## Test plan
- Reset with RESET_PC=16'h0010, zero-wait memory, pred_pc=pc+1 -> `pc` reads 0x10, 0x11, 0x12 on successive cycles; `if_id_valid` goes high one cycle after the first ready.
- pred_pc=16'h0040 for pc=0x12 -> the next fetch address is 0x40, and `if_id_pred_pc`=0x40 for the instruction at 0x12.
- stall=1 for 3 cycles while a completion occurs -> `i_mem_req`=0 during SKID, IF/ID unchanged; on release the buffered instruction appears in the next cycle with no loss or duplication.
- 3-cycle memory latency, redirect to 0x80 in the second wait cycle -> the returning data is dropped, `if_id_valid`=0, and the next request address is 0x80.
- Redirect in the same cycle as ready and stall -> data dropped, skid empty, `pc`=redirect_pc in the next cycle.
- Reset asserted during a pending request -> all outputs return to their reset values in the next cycle.
